// File: rtl/vic_pot_sampler_if.sv
// Signal bundle between the paddle chooser (master) and the VIC pot sampler (slave).
// The slave converts paddle targets into POTX/POTY values and comparator lines.
interface vic_pot_sampler_if;
    logic       ce;
    logic [7:0] pot_x_in;
    logic [7:0] pot_y_in;
    logic [1:0] pot_en;
    logic [7:0] pot_x;
    logic [7:0] pot_y;
    logic       pot_line_x;
    logic       pot_line_y;
    logic       sample_done;

    modport master (
        output ce, pot_x_in, pot_y_in, pot_en,
        input  pot_x, pot_y, pot_line_x, pot_line_y, sample_done
    );

    modport slave (
        input  ce, pot_x_in, pot_y_in, pot_en,
        output pot_x, pot_y, pot_line_x, pot_line_y, sample_done
    );
endinterface

// File: rtl/vic_pot_sampler.sv
// Emulates the VIC pot measurement cycle (discharge, then up-counting charge) and
// latches the count at which each emulated pot line crosses threshold into POTX/POTY.
module vic_pot_sampler #(
    parameter int unsigned DIS_TICKS = 256,
    parameter bit          AVERAGE   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    vic_pot_sampler_if.slave   bus
);

    typedef enum logic [1:0] {
        S_DISCHARGE = 2'd0,
        S_CHARGE    = 2'd1,
        S_LATCH     = 2'd2
    } state_e;

    localparam logic [9:0] DIS_LAST = 10'(DIS_TICKS - 1);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [9:0] r_dis_cnt;
    logic [7:0] r_cnt;
    logic [7:0] r_tx;
    logic [7:0] r_ty;
    logic [7:0] r_cap_x;
    logic [7:0] r_cap_y;
    logic [7:0] r_prev_x;
    logic [7:0] r_prev_y;
    logic [7:0] r_pot_x;
    logic [7:0] r_pot_y;
    logic       r_hit_x;
    logic       r_hit_y;
    logic       r_line_x;
    logic       r_line_y;
    logic       r_sample_done;

    logic       w_dis_last;
    logic       w_cnt_last;
    logic [7:0] w_new_x;
    logic [7:0] w_new_y;
    logic [7:0] w_upd_x;
    logic [7:0] w_upd_y;

    // Rounded mean in 9 bits; the shifted result always fits in 8.
    function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

    assign w_dis_last = bus.ce && (r_dis_cnt == DIS_LAST);
    assign w_cnt_last = bus.ce && (r_cnt == 8'hFF);

    assign w_new_x = (bus.pot_en[0] && r_hit_x) ? r_cap_x : 8'hFF;
    assign w_new_y = (bus.pot_en[1] && r_hit_y) ? r_cap_y : 8'hFF;
    assign w_upd_x = AVERAGE ? avg_round(r_prev_x, w_new_x) : w_new_x;
    assign w_upd_y = AVERAGE ? avg_round(r_prev_y, w_new_y) : w_new_y;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_DISCHARGE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: the default assigned first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_DISCHARGE: if (w_dis_last) w_state_nxt = S_CHARGE;
            S_CHARGE:    if (w_cnt_last) w_state_nxt = S_LATCH;
            S_LATCH:     w_state_nxt = S_DISCHARGE;
            default:     w_state_nxt = S_DISCHARGE;
        endcase
    end

    // NOTE: every datapath register has a reset value, so an abort mid-charge leaves nothing stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dis_cnt     <= '0;
            r_cnt         <= '0;
            r_tx          <= '0;
            r_ty          <= '0;
            r_cap_x       <= '0;
            r_cap_y       <= '0;
            r_prev_x      <= 8'hFF;
            r_prev_y      <= 8'hFF;
            r_pot_x       <= 8'hFF;
            r_pot_y       <= 8'hFF;
            r_hit_x       <= 1'b0;
            r_hit_y       <= 1'b0;
            r_line_x      <= 1'b0;
            r_line_y      <= 1'b0;
            r_sample_done <= 1'b0;
        end else begin
            r_sample_done <= 1'b0;
            case (r_state)
                S_DISCHARGE: begin
                    if (bus.ce) begin
                        r_dis_cnt <= r_dis_cnt + 10'd1;
                        if (w_dis_last) begin
                            r_tx    <= bus.pot_x_in;
                            r_ty    <= bus.pot_y_in;
                            r_cnt   <= '0;
                            r_hit_x <= 1'b0;
                            r_hit_y <= 1'b0;
                        end
                    end
                end
                S_CHARGE: begin
                    // Compare against the pre-increment count, then advance.
                    if (bus.ce) begin
                        if (!r_hit_x && (r_cnt >= r_tx)) begin
                            r_hit_x  <= 1'b1;
                            r_cap_x  <= r_cnt;
                            r_line_x <= 1'b1;
                        end
                        if (!r_hit_y && (r_cnt >= r_ty)) begin
                            r_hit_y  <= 1'b1;
                            r_cap_y  <= r_cnt;
                            r_line_y <= 1'b1;
                        end
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_LATCH: begin
                    r_pot_x       <= w_upd_x;
                    r_pot_y       <= w_upd_y;
                    r_prev_x      <= w_new_x;
                    r_prev_y      <= w_new_y;
                    r_sample_done <= 1'b1;
                    r_line_x      <= 1'b0;
                    r_line_y      <= 1'b0;
                    r_dis_cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.pot_x       = r_pot_x;
    assign bus.pot_y       = r_pot_y;
    assign bus.pot_line_x  = r_line_x;
    assign bus.pot_line_y  = r_line_y;
    assign bus.sample_done = r_sample_done;

endmodule

// File: tb/tb_vic_pot_sampler.sv
// Bench for vic_pot_sampler: a raw and an averaging instance share stimulus and are
// compared every clock against a tick-counting reference model of the measurement cycle.
module tb_vic_pot_sampler;

    localparam int DIS = 256;

    logic clk = 1'b0;
    logic reset;
    int   n_tests;
    int   n_fail;

    // Reference model register contents.
    logic [7:0] m_raw_x, m_raw_y;
    logic [7:0] m_avg_x, m_avg_y;
    logic [7:0] m_prev_x, m_prev_y;

    always #5 clk = ~clk;

    vic_pot_sampler_if if0 ();
    vic_pot_sampler_if if1 ();

    assign if1.ce       = if0.ce;
    assign if1.pot_x_in = if0.pot_x_in;
    assign if1.pot_y_in = if0.pot_y_in;
    assign if1.pot_en   = if0.pot_en;

    vic_pot_sampler #(.DIS_TICKS(DIS), .AVERAGE(1'b0)) u_raw (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    vic_pot_sampler #(.DIS_TICKS(DIS), .AVERAGE(1'b1)) u_avg (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive ce for one edge, then land 1 time unit after it.
    task automatic tick(input logic ce_v);
        if0.ce = ce_v;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input logic lx, input logic ly, input logic done);
        check({tag, "_raw"},
              {13'd0, if0.pot_x, if0.pot_y, if0.pot_line_x, if0.pot_line_y, if0.sample_done},
              {13'd0, m_raw_x, m_raw_y, lx, ly, done});
        check({tag, "_avg"},
              {13'd0, if1.pot_x, if1.pot_y, if1.pot_line_x, if1.pot_line_y, if1.sample_done},
              {13'd0, m_avg_x, m_avg_y, lx, ly, done});
    endtask

    function automatic logic [7:0] mean_up(input logic [7:0] a, input logic [7:0] b);
        return 8'((int'(a) + int'(b) + 1) / 2);
    endfunction

    // One measurement period, starting in discharge with zero ticks counted.
    // Inputs hold junk except at the snapshot tick; abort_at >= 0 asserts reset at that charge tick.
    task automatic run_period(input string tag, input int gap, input logic [7:0] x,
                              input logic [7:0] y, input logic [1:0] en, input bit has_mid,
                              input logic [7:0] x_mid, input int abort_at, input logic latch_ce);
        logic [7:0] nx, ny;
        logic       lx, ly;
        lx = 1'b0;
        ly = 1'b0;
        if0.pot_en   = en;
        if0.pot_x_in = ~x;
        if0.pot_y_in = ~y;
        for (int k = 0; k < DIS + 256; k++) begin
            if (k == DIS - 1) begin
                if0.pot_x_in = x;
                if0.pot_y_in = y;
            end
            for (int g = 1; g < gap; g++) begin
                tick(1'b0);
                sample(tag, lx, ly, 1'b0);
            end
            tick(1'b1);
            if (k == DIS - 1) begin
                if (!has_mid) if0.pot_x_in = 8'($urandom);
                if0.pot_y_in = 8'($urandom);
            end
            if (has_mid && k == DIS + 128) if0.pot_x_in = x_mid;
            if (k >= DIS) begin
                lx = lx | (int'(x) <= k - DIS);
                ly = ly | (int'(y) <= k - DIS);
            end
            if (abort_at >= 0 && k == DIS + abort_at) begin
                #2 reset = 1'b0;
                #1;
                m_raw_x = 8'hFF; m_raw_y = 8'hFF;
                m_avg_x = 8'hFF; m_avg_y = 8'hFF;
                m_prev_x = 8'hFF; m_prev_y = 8'hFF;
                sample({tag, "_rst"}, 1'b0, 1'b0, 1'b0);
                for (int r = 0; r < 3; r++) begin
                    tick(1'b1);
                    sample({tag, "_rsthold"}, 1'b0, 1'b0, 1'b0);
                end
                reset = 1'b1;
                return;
            end
            sample(tag, lx, ly, 1'b0);
        end
        tick(latch_ce);
        nx = en[0] ? x : 8'hFF;
        ny = en[1] ? y : 8'hFF;
        m_raw_x = nx;
        m_raw_y = ny;
        m_avg_x = mean_up(m_prev_x, nx);
        m_avg_y = mean_up(m_prev_y, ny);
        m_prev_x = nx;
        m_prev_y = ny;
        sample({tag, "_latch"}, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        if0.ce       = 1'b0;
        if0.pot_x_in = 8'h00;
        if0.pot_y_in = 8'h00;
        if0.pot_en   = 2'b11;
        m_raw_x = 8'hFF; m_raw_y = 8'hFF;
        m_avg_x = 8'hFF; m_avg_y = 8'hFF;
        m_prev_x = 8'hFF; m_prev_y = 8'hFF;

        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            sample("reset", 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;

        run_period("basic", 1, 8'h40, 8'hC0, 2'b11, 1'b0, 8'h00, -1, 1'b1);
        check("basic_x", 32'(if0.pot_x), 32'h40);
        check("basic_y", 32'(if0.pot_y), 32'hC0);
        check("basic_avg_x", 32'(if1.pot_x), 32'hA0);

        run_period("edges", 1, 8'h00, 8'hFF, 2'b11, 1'b0, 8'h00, -1, 1'b0);
        check("edges_xy", 32'({if0.pot_x, if0.pot_y}), 32'h00FF);

        run_period("midchg", 1, 8'h10, 8'h77, 2'b11, 1'b1, 8'h90, -1, 1'b1);
        check("midchg_x", 32'(if0.pot_x), 32'h10);
        run_period("next", 1, 8'h90, 8'h33, 2'b11, 1'b0, 8'h00, -1, 1'b0);
        check("next_x", 32'(if0.pot_x), 32'h90);

        run_period("en01", 2, 8'h5A, 8'h20, 2'b01, 1'b0, 8'h00, -1, 1'b1);
        check("en01_xy", 32'({if0.pot_x, if0.pot_y}), 32'h5AFF);

        for (int i = 0; i < 4; i++) begin
            run_period($sformatf("rnd%0d", i), int'($urandom_range(1, 2)), 8'($urandom),
                       8'($urandom), 2'($urandom), 1'b0, 8'h00, -1, 1'($urandom));
        end

        run_period("abort", 4, 8'h55, 8'hAA, 2'b11, 1'b0, 8'h00, 100, 1'b0);

        run_period("avg0", 4, 8'h00, 8'h20, 2'b11, 1'b0, 8'h00, -1, 1'b1);
        check("avg0_x", 32'(if1.pot_x), 32'h80);
        run_period("avg1", 4, 8'h81, 8'h20, 2'b11, 1'b0, 8'h00, -1, 1'b0);
        check("avg1_x", 32'(if1.pot_x), 32'h41);
        run_period("avg2", 4, 8'h81, 8'h20, 2'b11, 1'b0, 8'h00, -1, 1'b1);
        check("avg2_x", 32'(if1.pot_x), 32'h81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
